// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback sequencer.
// Packet layout, FSM states and the per-packet write plan.
package wb_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 4;
    localparam logic [REG_AW-1:0] PC_IDX = 4'd15;

    typedef enum logic [1:0] {
        IDLE,
        WR_FIRST,
        WR_SECOND
    } wb_state_t;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              rd_en;
        logic [DATA_W-1:0] rd_data;
        logic [REG_AW-1:0] rn;
        logic              rn_en;
        logic [DATA_W-1:0] rn_data;
        logic              pc_en;
        logic [DATA_W-1:0] pc;
        logic              cpsr_en;
        logic [DATA_W-1:0] cpsr;
    } wb_pkt_t;

    // Resolved view of a packet: what WR_FIRST drives and what is left for WR_SECOND.
    typedef struct packed {
        logic              reg_en;
        logic [REG_AW-1:0] reg_num;
        logic [DATA_W-1:0] reg_data;
        logic              pc_en;
        logic [DATA_W-1:0] pc_data;
        logic              cpsr_en;
        logic [DATA_W-1:0] cpsr_data;
        logic              second_pending;
        logic [REG_AW-1:0] second_num;
        logic [DATA_W-1:0] second_data;
    } wb_plan_t;

    function automatic logic is_pc(input logic [REG_AW-1:0] idx);
        return idx == PC_IDX;
    endfunction

endpackage

// File: rtl/wb_pc_resolve.sv
// Combinational resolution of a writeback packet into a two-cycle write plan,
// applying the PC-alias priority and rd/rn collision rules.
module wb_pc_resolve
    import wb_pkg::*;
(
    input  wb_pkt_t  pkt,
    output wb_plan_t plan
);

    logic rd_pc;
    logic rn_live;
    logic rn_pc;

    assign rd_pc   = pkt.rd_en && is_pc(pkt.rd);
    // A base write to the same register as rd is dropped; rd wins.
    assign rn_live = pkt.rn_en && !(pkt.rd_en && (pkt.rd == pkt.rn));
    assign rn_pc   = rn_live && is_pc(pkt.rn);

    // NOTE: every output gets a default first so no path leaves a value held, which would infer a latch.
    always_comb begin
        plan = '0;

        if (pkt.rd_en) begin
            plan.reg_en   = !rd_pc;
            plan.reg_num  = pkt.rd;
            plan.reg_data = pkt.rd_data;
        end else if (rn_live) begin
            plan.reg_en   = !rn_pc;
            plan.reg_num  = pkt.rn;
            plan.reg_data = pkt.rn_data;
        end

        // rd alias beats explicit PC, which beats an rn alias.
        if (rd_pc) begin
            plan.pc_en   = 1'b1;
            plan.pc_data = pkt.rd_data;
        end else if (pkt.pc_en) begin
            plan.pc_en   = 1'b1;
            plan.pc_data = pkt.pc;
        end else if (rn_pc) begin
            plan.pc_en   = 1'b1;
            plan.pc_data = pkt.rn_data;
        end

        plan.cpsr_en   = pkt.cpsr_en;
        plan.cpsr_data = pkt.cpsr;

        // A PC-aliased base write is folded into WR_FIRST, never given its own cycle.
        plan.second_pending = pkt.rd_en && rn_live && !rn_pc;
        plan.second_num     = pkt.rn;
        plan.second_data    = pkt.rn_data;
    end

endmodule

// File: rtl/wb_sequencer.sv
// Writeback sequencer: serialises packet register writes onto the shared register port.
// Optional forwarding outputs are built when WB_SEQ_BYPASS_EN is defined.
module wb_sequencer
    import wb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_rd_en,
    input  logic [DATA_W-1:0] in_rd_data,
    input  logic [REG_AW-1:0] in_rn,
    input  logic              in_rn_en,
    input  logic [DATA_W-1:0] in_rn_data,
    input  logic              in_pc_en,
    input  logic [DATA_W-1:0] in_pc,
    input  logic              in_cpsr_en,
    input  logic [DATA_W-1:0] in_cpsr,
    input  logic [REG_AW-1:0] rd_req_num,
    output logic              rd_stall,
    output logic [REG_AW-1:0] reg_num,
    output logic              reg_write_en,
    output logic [DATA_W-1:0] reg_data_in,
    output logic [DATA_W-1:0] pc_in,
    output logic              pc_write_en,
`ifdef WB_SEQ_BYPASS_EN
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_num,
    output logic [DATA_W-1:0] fwd_data,
`endif
    output logic [DATA_W-1:0] cpsr_in,
    output logic              cpsr_write_en
);

    wb_state_t state;
    wb_state_t state_next;
    wb_pkt_t   pkt;
    wb_pkt_t   in_pkt;
    wb_plan_t  plan;
    logic      accept;

    assign in_pkt = '{
        rd:      in_rd,
        rd_en:   in_rd_en,
        rd_data: in_rd_data,
        rn:      in_rn,
        rn_en:   in_rn_en,
        rn_data: in_rn_data,
        pc_en:   in_pc_en,
        pc:      in_pc,
        cpsr_en: in_cpsr_en,
        cpsr:    in_cpsr
    };

    wb_pc_resolve u_resolve (
        .pkt  (pkt),
        .plan (plan)
    );

    // NOTE: state and the captured packet use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            pkt   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                pkt <= in_pkt;
            end
        end
    end

    always_comb begin
        state_next    = state;
        in_ready      = 1'b0;
        accept        = 1'b0;
        reg_num       = rd_req_num;
        reg_write_en  = 1'b0;
        reg_data_in   = '0;
        pc_in         = '0;
        pc_write_en   = 1'b0;
        cpsr_in       = '0;
        cpsr_write_en = 1'b0;

        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
            end
            WR_FIRST: begin
                in_ready     = !plan.second_pending;
                reg_write_en = plan.reg_en;
                if (plan.reg_en) begin
                    reg_num     = plan.reg_num;
                    reg_data_in = plan.reg_data;
                end
                pc_write_en   = plan.pc_en;
                pc_in         = plan.pc_en ? plan.pc_data : '0;
                cpsr_write_en = plan.cpsr_en;
                cpsr_in       = plan.cpsr_en ? plan.cpsr_data : '0;
            end
            WR_SECOND: begin
                in_ready     = 1'b1;
                reg_write_en = 1'b1;
                reg_num      = plan.second_num;
                reg_data_in  = plan.second_data;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase

        // Reset dominates: nothing is lent out as a write while it is held.
        if (!reset) begin
            in_ready      = 1'b0;
            reg_num       = rd_req_num;
            reg_write_en  = 1'b0;
            reg_data_in   = '0;
            pc_in         = '0;
            pc_write_en   = 1'b0;
            cpsr_in       = '0;
            cpsr_write_en = 1'b0;
        end

        accept = in_valid && in_ready;

        unique case (state)
            IDLE:      state_next = accept ? WR_FIRST : IDLE;
            WR_FIRST:  state_next = plan.second_pending ? WR_SECOND :
                                    (accept ? WR_FIRST : IDLE);
            WR_SECOND: state_next = accept ? WR_FIRST : IDLE;
            default:   state_next = IDLE;
        endcase
    end

    assign rd_stall = reg_write_en;

`ifdef WB_SEQ_BYPASS_EN
    always_comb begin
        fwd_valid = 1'b0;
        fwd_num   = '0;
        fwd_data  = '0;
        if (reset && ((state == WR_FIRST && plan.second_pending) || state == WR_SECOND)) begin
            fwd_valid = 1'b1;
            fwd_num   = plan.second_num;
            fwd_data  = plan.second_data;
        end
    end
`endif

endmodule

// File: tb/tb_wb_sequencer.sv
// Directed self-checking bench for wb_sequencer.
// Inputs change and outputs are sampled 1-2 time units after each rising edge.
module tb_wb_sequencer;
    import wb_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [REG_AW-1:0] in_rd;
    logic              in_rd_en;
    logic [DATA_W-1:0] in_rd_data;
    logic [REG_AW-1:0] in_rn;
    logic              in_rn_en;
    logic [DATA_W-1:0] in_rn_data;
    logic              in_pc_en;
    logic [DATA_W-1:0] in_pc;
    logic              in_cpsr_en;
    logic [DATA_W-1:0] in_cpsr;
    logic [REG_AW-1:0] rd_req_num;
    logic              rd_stall;
    logic [REG_AW-1:0] reg_num;
    logic              reg_write_en;
    logic [DATA_W-1:0] reg_data_in;
    logic [DATA_W-1:0] pc_in;
    logic              pc_write_en;
    logic [DATA_W-1:0] cpsr_in;
    logic              cpsr_write_en;
`ifdef WB_SEQ_BYPASS_EN
    logic              fwd_valid;
    logic [REG_AW-1:0] fwd_num;
    logic [DATA_W-1:0] fwd_data;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rd         (in_rd),
        .in_rd_en      (in_rd_en),
        .in_rd_data    (in_rd_data),
        .in_rn         (in_rn),
        .in_rn_en      (in_rn_en),
        .in_rn_data    (in_rn_data),
        .in_pc_en      (in_pc_en),
        .in_pc         (in_pc),
        .in_cpsr_en    (in_cpsr_en),
        .in_cpsr       (in_cpsr),
        .rd_req_num    (rd_req_num),
        .rd_stall      (rd_stall),
        .reg_num       (reg_num),
        .reg_write_en  (reg_write_en),
        .reg_data_in   (reg_data_in),
        .pc_in         (pc_in),
        .pc_write_en   (pc_write_en),
`ifdef WB_SEQ_BYPASS_EN
        .fwd_valid     (fwd_valid),
        .fwd_num       (fwd_num),
        .fwd_data      (fwd_data),
`endif
        .cpsr_in       (cpsr_in),
        .cpsr_write_en (cpsr_write_en)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pkt();
        in_rd = '0; in_rd_en = 1'b0; in_rd_data = '0;
        in_rn = '0; in_rn_en = 1'b0; in_rn_data = '0;
        in_pc_en = 1'b0; in_pc = '0;
        in_cpsr_en = 1'b0; in_cpsr = '0;
    endtask

    task automatic set_rd(input logic [REG_AW-1:0] r, input logic [DATA_W-1:0] d);
        in_rd = r; in_rd_en = 1'b1; in_rd_data = d;
    endtask

    task automatic set_rn(input logic [REG_AW-1:0] r, input logic [DATA_W-1:0] d);
        in_rn = r; in_rn_en = 1'b1; in_rn_data = d;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; rd_req_num = 4'd9; clear_pkt();
        step(); step();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b exp=0", in_ready); end
        checks++; if ({reg_write_en, pc_write_en, cpsr_write_en} !== 3'b000) begin failures++; $display("FAIL reset_strobes got=%b exp=000", {reg_write_en, pc_write_en, cpsr_write_en}); end
        checks++; if (reg_num !== 4'd9) begin failures++; $display("FAIL reset_reg_num got=%0d exp=9", reg_num); end
        checks++; if ({reg_data_in, pc_in, cpsr_in} !== '0) begin failures++; $display("FAIL reset_data got=%h/%h/%h exp=0", reg_data_in, pc_in, cpsr_in); end
        reset = 1'b1; #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_single();
        clear_pkt(); set_rd(4'd3, 32'hDEADBEEF); in_valid = 1'b1;
        step();
        in_valid = 1'b0; clear_pkt(); #1;
        checks++; if ({reg_num, reg_write_en, rd_stall} !== {4'd3, 1'b1, 1'b1}) begin failures++; $display("FAIL single_write num=%0d we=%0b stall=%0b exp=3/1/1", reg_num, reg_write_en, rd_stall); end
        checks++; if (reg_data_in !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data got=%h exp=deadbeef", reg_data_in); end
        step();
        rd_req_num = 4'd7; #1;
        checks++; if ({reg_num, reg_write_en, in_ready} !== {4'd7, 1'b0, 1'b1}) begin failures++; $display("FAIL single_idle num=%0d we=%0b rdy=%0b exp=7/0/1", reg_num, reg_write_en, in_ready); end
    endtask

    task automatic test_dual();
        int strobes = 0;
        clear_pkt(); set_rd(4'd2, 32'h11); set_rn(4'd5, 32'h2000); in_valid = 1'b1;
        step();
        in_valid = 1'b0; clear_pkt(); #1;
        strobes += int'(reg_write_en);
        checks++; if ({reg_num, reg_data_in, in_ready} !== {4'd2, 32'h11, 1'b0}) begin failures++; $display("FAIL dual_first num=%0d data=%h rdy=%0b exp=2/11/0", reg_num, reg_data_in, in_ready); end
        step();
        strobes += int'(reg_write_en);
        checks++; if ({reg_num, reg_data_in, in_ready} !== {4'd5, 32'h2000, 1'b1}) begin failures++; $display("FAIL dual_second num=%0d data=%h rdy=%0b exp=5/2000/1", reg_num, reg_data_in, in_ready); end
        step();
        strobes += int'(reg_write_en);
        checks++; if (strobes != 2) begin failures++; $display("FAIL dual_strobes got=%0d exp=2", strobes); end
    endtask

    task automatic test_pc_alias();
        clear_pkt(); set_rd(4'd15, 32'h100);
        in_pc_en = 1'b1; in_pc = 32'h200; in_cpsr_en = 1'b1; in_cpsr = 32'h600000D3;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0; clear_pkt(); #1;
        checks++; if ({pc_in, pc_write_en} !== {32'h100, 1'b1}) begin failures++; $display("FAIL alias_pc pc=%h we=%0b exp=100/1", pc_in, pc_write_en); end
        checks++; if ({cpsr_in, cpsr_write_en} !== {32'h600000D3, 1'b1}) begin failures++; $display("FAIL alias_cpsr cpsr=%h we=%0b exp=600000d3/1", cpsr_in, cpsr_write_en); end
        checks++; if ({reg_write_en, rd_stall, in_ready} !== 3'b001) begin failures++; $display("FAIL alias_reg we=%0b stall=%0b rdy=%0b exp=0/0/1", reg_write_en, rd_stall, in_ready); end
        step();
        checks++; if ({pc_write_en, cpsr_write_en} !== 2'b00) begin failures++; $display("FAIL alias_pulse pc_we=%0b cpsr_we=%0b exp=0/0", pc_write_en, cpsr_write_en); end
    endtask

    task automatic test_pc_priority();
        // Explicit PC beats an rn alias; no register write at all.
        clear_pkt(); set_rn(4'd15, 32'h300); in_pc_en = 1'b1; in_pc = 32'h200; in_valid = 1'b1;
        step();
        in_valid = 1'b0; clear_pkt(); #1;
        checks++; if ({pc_in, pc_write_en, reg_write_en, in_ready} !== {32'h200, 1'b1, 1'b0, 1'b1}) begin failures++; $display("FAIL prio_pc pc=%h we=%0b rwe=%0b rdy=%0b exp=200/1/0/1", pc_in, pc_write_en, reg_write_en, in_ready); end
        step();
        // rn alias alone folds into WR_FIRST alongside the rd write.
        clear_pkt(); set_rd(4'd1, 32'h55); set_rn(4'd15, 32'h300); in_valid = 1'b1;
        step();
        in_valid = 1'b0; clear_pkt(); #1;
        checks++; if ({reg_num, reg_data_in, reg_write_en} !== {4'd1, 32'h55, 1'b1}) begin failures++; $display("FAIL fold_reg num=%0d data=%h we=%0b exp=1/55/1", reg_num, reg_data_in, reg_write_en); end
        checks++; if ({pc_in, pc_write_en, in_ready} !== {32'h300, 1'b1, 1'b1}) begin failures++; $display("FAIL fold_pc pc=%h we=%0b rdy=%0b exp=300/1/1", pc_in, pc_write_en, in_ready); end
        step();
        checks++; if ({reg_write_en, pc_write_en} !== 2'b00) begin failures++; $display("FAIL fold_done rwe=%0b pwe=%0b exp=0/0", reg_write_en, pc_write_en); end
    endtask

    task automatic test_collision();
        clear_pkt(); set_rd(4'd4, 32'hAA); set_rn(4'd4, 32'hBB); in_valid = 1'b1;
        step();
        in_valid = 1'b0; clear_pkt(); #1;
        checks++; if ({reg_num, reg_data_in, reg_write_en, in_ready} !== {4'd4, 32'hAA, 1'b1, 1'b1}) begin failures++; $display("FAIL collide_write num=%0d data=%h we=%0b rdy=%0b exp=4/aa/1/1", reg_num, reg_data_in, reg_write_en, in_ready); end
        step();
        checks++; if (reg_write_en !== 1'b0) begin failures++; $display("FAIL collide_second we=%0b exp=0", reg_write_en); end
    endtask

    task automatic test_back_to_back();
        clear_pkt(); set_rd(4'd6, 32'h1000); in_valid = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                set_rd(4'(6 + i + 1), 32'h1000 + 32'(i + 1));
            end else begin
                in_valid = 1'b0; clear_pkt();
            end
            #1;
            checks++;
            if ({reg_write_en, reg_num, reg_data_in, in_ready} !== {1'b1, 4'(6 + i), 32'h1000 + 32'(i), 1'b1}) begin
                failures++;
                $display("FAIL b2b_%0d we=%0b num=%0d data=%h rdy=%0b exp=1/%0d/%h/1", i, reg_write_en, reg_num, reg_data_in, in_ready, 6 + i, 32'h1000 + 32'(i));
            end
            step();
        end
        checks++; if (reg_write_en !== 1'b0) begin failures++; $display("FAIL b2b_end we=%0b exp=0", reg_write_en); end
    endtask

    task automatic test_reset_mid();
        int rn_writes = 0;
        rd_req_num = 4'd8;
        clear_pkt(); set_rd(4'd2, 32'h11); set_rn(4'd5, 32'h2000); in_valid = 1'b1;
        step();
        in_valid = 1'b0; clear_pkt(); #1;
        checks++; if ({reg_num, reg_write_en} !== {4'd2, 1'b1}) begin failures++; $display("FAIL mid_first num=%0d we=%0b exp=2/1", reg_num, reg_write_en); end
        step();
        reset = 1'b0; #1;
        if (reg_write_en && reg_num == 4'd5) rn_writes++;
        checks++; if ({reg_write_en, reg_num} !== {1'b0, 4'd8}) begin failures++; $display("FAIL mid_held we=%0b num=%0d exp=0/8", reg_write_en, reg_num); end
        step();
        if (reg_write_en && reg_num == 4'd5) rn_writes++;
        checks++; if ({reg_write_en, pc_write_en, cpsr_write_en, in_ready} !== 4'b0000) begin failures++; $display("FAIL mid_reset strobes=%b rdy=%0b exp=000/0", {reg_write_en, pc_write_en, cpsr_write_en}, in_ready); end
        reset = 1'b1; #1;
        if (reg_write_en && reg_num == 4'd5) rn_writes++;
        checks++; if ({reg_write_en, in_ready} !== 2'b01) begin failures++; $display("FAIL mid_idle we=%0b rdy=%0b exp=0/1", reg_write_en, in_ready); end
        checks++; if (rn_writes != 0) begin failures++; $display("FAIL mid_rn_writes got=%0d exp=0", rn_writes); end
        clear_pkt(); set_rd(4'd1, 32'h77); in_valid = 1'b1;
        step();
        in_valid = 1'b0; clear_pkt(); #1;
        checks++; if ({reg_num, reg_data_in, reg_write_en} !== {4'd1, 32'h77, 1'b1}) begin failures++; $display("FAIL mid_after num=%0d data=%h we=%0b exp=1/77/1", reg_num, reg_data_in, reg_write_en); end
        step();
        checks++; if ({reg_write_en, reg_num} !== {1'b0, 4'd8}) begin failures++; $display("FAIL mid_after_idle we=%0b num=%0d exp=0/8", reg_write_en, reg_num); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_dual();
        test_pc_alias();
        test_pc_priority();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
